// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings used by the bus masters and slaves of this codebase.
package ahbl_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    // Data access, privileged, non-bufferable, non-cacheable.
    localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

endpackage

// File: rtl/ahbl_master_bridge.sv
// Valid/ready request stream to single AHB-Lite transfers, one response per request.
// Optional feature macro: AHBL_MASTER_BRIDGE_PIPELINE_EN (overlap address and data phases).
module ahbl_master_bridge
    import ahbl_pkg::*;
#(
    parameter int W_ADDR = 32,
    parameter int W_DATA = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [W_ADDR-1:0] req_addr,
    input  logic              req_write,
    input  logic [2:0]        req_size,
    input  logic [W_DATA-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [W_DATA-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [W_ADDR-1:0] ahblm_haddr,
    output logic              ahblm_hwrite,
    output logic [1:0]        ahblm_htrans,
    output logic [2:0]        ahblm_hsize,
    output logic [2:0]        ahblm_hburst,
    output logic [3:0]        ahblm_hprot,
    output logic              ahblm_hmastlock,
    output logic [W_DATA-1:0] ahblm_hwdata,
    input  logic              ahblm_hready,
    input  logic              ahblm_hresp,
    input  logic [W_DATA-1:0] ahblm_hrdata
);

    logic              aph_valid_r;
    logic [W_ADDR-1:0] aph_addr_r;
    logic              aph_write_r;
    logic [2:0]        aph_size_r;
    logic [W_DATA-1:0] aph_wdata_r;

    logic              dph_valid_r;
    logic              dph_write_r;
    logic [W_DATA-1:0] dph_wdata_r;

    logic              err_first_s;
    logic              req_ready_s;
    logic              accept_s;

    // First cycle of a two-cycle ERROR: the pending address phase must be shown as IDLE.
    assign err_first_s = dph_valid_r & ahblm_hresp & ~ahblm_hready;
    assign accept_s    = req_valid & req_ready_s;

    // Request acceptance: overlapped with the data phase only when pipelining is built in.
    always_comb begin
        req_ready_s = 1'b0;
`ifdef AHBL_MASTER_BRIDGE_PIPELINE_EN
        if (!aph_valid_r) begin
            req_ready_s = 1'b1;
        end else begin
            req_ready_s = ahblm_hready & ~err_first_s;
        end
`else
        if (!aph_valid_r && !dph_valid_r) begin
            req_ready_s = 1'b1;
        end else begin
            req_ready_s = 1'b0;
        end
`endif
    end

    // Address-phase register: loads on accept, empties once the bus samples it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aph_valid_r <= 1'b0;
            aph_addr_r  <= '0;
            aph_write_r <= 1'b0;
            aph_size_r  <= 3'b000;
            aph_wdata_r <= '0;
        end else if (accept_s) begin
            aph_valid_r <= 1'b1;
            aph_addr_r  <= req_addr;
            aph_write_r <= req_write;
            aph_size_r  <= req_size;
            aph_wdata_r <= req_wdata;
        end else if (ahblm_hready) begin
            aph_valid_r <= 1'b0;
        end
    end

    // Data-phase register: advances only on hready so wait states hold everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dph_valid_r <= 1'b0;
            dph_write_r <= 1'b0;
            dph_wdata_r <= '0;
        end else if (ahblm_hready) begin
            dph_valid_r <= aph_valid_r;
            dph_write_r <= aph_write_r;
            dph_wdata_r <= aph_wdata_r;
        end
    end

    // Transfer type: the held transfer reappears as NONSEQ in the second error cycle.
    always_comb begin
        ahblm_htrans = HTRANS_IDLE;
        if (aph_valid_r && !err_first_s) begin
            ahblm_htrans = HTRANS_NONSEQ;
        end else begin
            ahblm_htrans = HTRANS_IDLE;
        end
    end

    // Response is taken straight from the completing data phase; no backpressure.
    always_comb begin
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = '0;
        if (dph_valid_r && ahblm_hready) begin
            rsp_valid = 1'b1;
            rsp_err   = ahblm_hresp;
            if (!dph_write_r) begin
                rsp_rdata = ahblm_hrdata;
            end else begin
                rsp_rdata = '0;
            end
        end else begin
            rsp_valid = 1'b0;
            rsp_err   = 1'b0;
            rsp_rdata = '0;
        end
    end

    assign req_ready       = req_ready_s;
    assign ahblm_haddr     = aph_addr_r;
    assign ahblm_hwrite    = aph_write_r;
    assign ahblm_hsize     = aph_size_r;
    assign ahblm_hburst    = HBURST_SINGLE;
    assign ahblm_hprot     = HPROT_DEFAULT;
    assign ahblm_hmastlock = 1'b0;
    assign ahblm_hwdata    = dph_wdata_r;

endmodule

// File: tb/tb_ahbl_master_bridge.sv
// Directed table-driven bench for ahbl_master_bridge; expectations follow the build's pipeline macro.
module tb_ahbl_master_bridge;
    import ahbl_pkg::*;

`ifdef AHBL_MASTER_BRIDGE_PIPELINE_EN
    localparam logic P = 1'b1;
`else
    localparam logic P = 1'b0;
`endif
    localparam logic        H   = 1'b1;
    localparam logic        L   = 1'b0;
    localparam logic [31:0] Z32 = 32'h0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_write;
    logic        req_ready;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_size;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] haddr, hwdata, hrdata;
    logic        hwrite, hmastlock, hready, hresp;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic rv; logic [31:0] addr; logic wr; logic [2:0] sz; logic [31:0] wd;
        logic hr; logic hresp; logic [31:0] hrd;
        logic e_rdy; logic e_ns; logic [31:0] e_addr; logic e_wr; logic [2:0] e_sz;
        logic chk_wd; logic [31:0] e_wd;
        logic e_rv; logic e_err; logic chk_rd; logic [31:0] e_rd;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    ahbl_master_bridge #(.W_ADDR(32), .W_DATA(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_size(req_size), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ahblm_haddr(haddr), .ahblm_hwrite(hwrite), .ahblm_htrans(htrans),
        .ahblm_hsize(hsize), .ahblm_hburst(hburst), .ahblm_hprot(hprot),
        .ahblm_hmastlock(hmastlock), .ahblm_hwdata(hwdata),
        .ahblm_hready(hready), .ahblm_hresp(hresp), .ahblm_hrdata(hrdata)
    );

    function automatic void chk(input string name, input int idx,
                                input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endfunction

    function automatic void add(
        input logic rv, input logic [31:0] addr, input logic wr, input logic [2:0] sz,
        input logic [31:0] wd, input logic hr, input logic hrs, input logic [31:0] hrd,
        input logic e_rdy, input logic e_ns, input logic [31:0] e_addr, input logic e_wr,
        input logic [2:0] e_sz, input logic chk_wd, input logic [31:0] e_wd,
        input logic e_rv, input logic e_err, input logic chk_rd, input logic [31:0] e_rd);
        vec_t v;
        v.rv = rv; v.addr = addr; v.wr = wr; v.sz = sz; v.wd = wd;
        v.hr = hr; v.hresp = hrs; v.hrd = hrd;
        v.e_rdy = e_rdy; v.e_ns = e_ns; v.e_addr = e_addr; v.e_wr = e_wr; v.e_sz = e_sz;
        v.chk_wd = chk_wd; v.e_wd = e_wd;
        v.e_rv = e_rv; v.e_err = e_err; v.chk_rd = chk_rd; v.e_rd = e_rd;
        vecs.push_back(v);
    endfunction

    function automatic void idle();
        add(L, Z32, L, HSIZE_BYTE, Z32, H, L, Z32, H, L, Z32, L, HSIZE_BYTE, L, Z32, L, L, L, Z32);
    endfunction

    task automatic drive(input logic rv, input logic [31:0] a, input logic w, input logic [2:0] s,
                         input logic [31:0] d, input logic hr, input logic hrs, input logic [31:0] hrd);
        req_valid = rv; req_addr = a; req_write = w; req_size = s; req_wdata = d;
        hready = hr; hresp = hrs; hrdata = hrd;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Single read, zero wait states.
        add(H, 32'h100, L, HSIZE_WORD, Z32, H, L, Z32, H, L, Z32, L, HSIZE_BYTE, L, Z32, L, L, L, Z32);
        add(L, Z32, L, HSIZE_BYTE, Z32, H, L, Z32, P, H, 32'h100, L, HSIZE_WORD, L, Z32, L, L, L, Z32);
        add(L, Z32, L, HSIZE_BYTE, Z32, H, L, 32'hDEADBEEF, P, L, Z32, L, HSIZE_BYTE, L, Z32, H, L, H, 32'hDEADBEEF);
        idle();
        // Halfword write with two slave wait states.
        add(H, 32'h40, H, HSIZE_HALF, 32'h11223344, H, L, Z32, H, L, Z32, L, HSIZE_BYTE, L, Z32, L, L, L, Z32);
        add(L, Z32, L, HSIZE_BYTE, Z32, H, L, Z32, P, H, 32'h40, H, HSIZE_HALF, L, Z32, L, L, L, Z32);
        add(L, Z32, L, HSIZE_BYTE, Z32, L, L, Z32, P, L, Z32, L, HSIZE_BYTE, H, 32'h11223344, L, L, L, Z32);
        add(L, Z32, L, HSIZE_BYTE, Z32, L, L, Z32, P, L, Z32, L, HSIZE_BYTE, H, 32'h11223344, L, L, L, Z32);
        add(L, Z32, L, HSIZE_BYTE, Z32, H, L, Z32, P, L, Z32, L, HSIZE_BYTE, H, 32'h11223344, H, L, L, Z32);
        idle();
`ifdef AHBL_MASTER_BRIDGE_PIPELINE_EN
        // ERROR on a byte write while a read to 0x20 waits in the address phase.
        add(H, 32'h30, H, HSIZE_BYTE, 32'hA5A5A5A5, H, L, Z32, H, L, Z32, L, HSIZE_BYTE, L, Z32, L, L, L, Z32);
        add(H, 32'h20, L, HSIZE_WORD, Z32, H, L, Z32, H, H, 32'h30, H, HSIZE_BYTE, L, Z32, L, L, L, Z32);
        add(L, Z32, L, HSIZE_BYTE, Z32, L, H, Z32, L, L, Z32, L, HSIZE_BYTE, H, 32'hA5A5A5A5, L, L, L, Z32);
        add(L, Z32, L, HSIZE_BYTE, Z32, H, H, Z32, H, H, 32'h20, L, HSIZE_WORD, H, 32'hA5A5A5A5, H, H, L, Z32);
        add(L, Z32, L, HSIZE_BYTE, Z32, H, L, 32'h12345678, H, L, Z32, L, HSIZE_BYTE, L, Z32, H, L, H, 32'h12345678);
        idle();
        // Back-to-back writes: one transfer per cycle, hwdata one cycle behind haddr.
        add(H, 32'h0, H, HSIZE_WORD, 32'hC0DE0000, H, L, Z32, H, L, Z32, L, HSIZE_BYTE, L, Z32, L, L, L, Z32);
        add(H, 32'h4, H, HSIZE_WORD, 32'hC0DE0001, H, L, Z32, H, H, 32'h0, H, HSIZE_WORD, L, Z32, L, L, L, Z32);
        add(H, 32'h8, H, HSIZE_WORD, 32'hC0DE0002, H, L, Z32, H, H, 32'h4, H, HSIZE_WORD, H, 32'hC0DE0000, H, L, L, Z32);
        add(L, Z32, L, HSIZE_BYTE, Z32, H, L, Z32, H, H, 32'h8, H, HSIZE_WORD, H, 32'hC0DE0001, H, L, L, Z32);
        add(L, Z32, L, HSIZE_BYTE, Z32, H, L, Z32, H, L, Z32, L, HSIZE_BYTE, H, 32'hC0DE0002, H, L, L, Z32);
        idle();
        // Two reads, the first with two wait states: second address phase held for 3 cycles.
        add(H, 32'h100, L, HSIZE_WORD, Z32, H, L, Z32, H, L, Z32, L, HSIZE_BYTE, L, Z32, L, L, L, Z32);
        add(H, 32'h104, L, HSIZE_WORD, Z32, H, L, Z32, H, H, 32'h100, L, HSIZE_WORD, L, Z32, L, L, L, Z32);
        add(L, Z32, L, HSIZE_BYTE, Z32, L, L, Z32, L, H, 32'h104, L, HSIZE_WORD, L, Z32, L, L, L, Z32);
        add(L, Z32, L, HSIZE_BYTE, Z32, L, L, Z32, L, H, 32'h104, L, HSIZE_WORD, L, Z32, L, L, L, Z32);
        add(L, Z32, L, HSIZE_BYTE, Z32, H, L, 32'hAAAA0001, H, H, 32'h104, L, HSIZE_WORD, L, Z32, H, L, H, 32'hAAAA0001);
        add(L, Z32, L, HSIZE_BYTE, Z32, H, L, 32'hBBBB0002, H, L, Z32, L, HSIZE_BYTE, L, Z32, H, L, H, 32'hBBBB0002);
        idle();
`else
        // ERROR on a byte write; the following read is held off until the bus is free.
        add(H, 32'h30, H, HSIZE_BYTE, 32'hA5A5A5A5, H, L, Z32, H, L, Z32, L, HSIZE_BYTE, L, Z32, L, L, L, Z32);
        add(H, 32'h20, L, HSIZE_WORD, Z32, H, L, Z32, L, H, 32'h30, H, HSIZE_BYTE, L, Z32, L, L, L, Z32);
        add(H, 32'h20, L, HSIZE_WORD, Z32, L, H, Z32, L, L, Z32, L, HSIZE_BYTE, H, 32'hA5A5A5A5, L, L, L, Z32);
        add(H, 32'h20, L, HSIZE_WORD, Z32, H, H, Z32, L, L, Z32, L, HSIZE_BYTE, H, 32'hA5A5A5A5, H, H, L, Z32);
        add(H, 32'h20, L, HSIZE_WORD, Z32, H, L, Z32, H, L, Z32, L, HSIZE_BYTE, L, Z32, L, L, L, Z32);
        add(L, Z32, L, HSIZE_BYTE, Z32, H, L, Z32, L, H, 32'h20, L, HSIZE_WORD, L, Z32, L, L, L, Z32);
        add(L, Z32, L, HSIZE_BYTE, Z32, H, L, 32'h12345678, L, L, Z32, L, HSIZE_BYTE, L, Z32, H, L, H, 32'h12345678);
        idle();
        // Four writes presented continuously: one transfer every three cycles, no overlap.
        for (int i = 0; i < 4; i++) begin
            logic [31:0] a_cur, a_nxt, d_cur, d_nxt;
            logic        more;
            a_cur = 32'(4 * i);
            d_cur = 32'hC0DE0000 + 32'(i);
            a_nxt = 32'(4 * (i + 1));
            d_nxt = 32'hC0DE0000 + 32'(i + 1);
            more  = (i < 3) ? H : L;
            add(H, a_cur, H, HSIZE_WORD, d_cur, H, L, Z32, H, L, Z32, L, HSIZE_BYTE, L, Z32, L, L, L, Z32);
            add(more, a_nxt, H, HSIZE_WORD, d_nxt, H, L, Z32, L, H, a_cur, H, HSIZE_WORD, L, Z32, L, L, L, Z32);
            add(more, a_nxt, H, HSIZE_WORD, d_nxt, H, L, Z32, L, L, Z32, L, HSIZE_BYTE, H, d_cur, H, L, L, Z32);
        end
        idle();
`endif

        // Power-on reset values and constant sideband outputs.
        rst_n = 1'b0;
        drive(L, Z32, L, HSIZE_BYTE, Z32, H, L, Z32);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 0, 32'(req_ready), 32'h1);
        chk("rst_htrans", 0, 32'(htrans), 32'(HTRANS_IDLE));
        chk("rst_haddr", 0, haddr, Z32);
        chk("rst_hwrite", 0, 32'(hwrite), Z32);
        chk("rst_hsize", 0, 32'(hsize), Z32);
        chk("rst_hwdata", 0, hwdata, Z32);
        chk("rst_rsp_valid", 0, 32'(rsp_valid), Z32);
        chk("rst_rsp_err", 0, 32'(rsp_err), Z32);
        chk("hburst", 0, 32'(hburst), 32'(HBURST_SINGLE));
        chk("hprot", 0, 32'(hprot), 32'h3);
        chk("hmastlock", 0, 32'(hmastlock), Z32);
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            @(posedge clk);
            #1;
            drive(vecs[k].rv, vecs[k].addr, vecs[k].wr, vecs[k].sz, vecs[k].wd,
                  vecs[k].hr, vecs[k].hresp, vecs[k].hrd);
            @(negedge clk);
            chk("req_ready", k, 32'(req_ready), 32'(vecs[k].e_rdy));
            chk("htrans", k, 32'(htrans), vecs[k].e_ns ? 32'(HTRANS_NONSEQ) : 32'(HTRANS_IDLE));
            if (vecs[k].e_ns) begin
                chk("haddr", k, haddr, vecs[k].e_addr);
                chk("hwrite", k, 32'(hwrite), 32'(vecs[k].e_wr));
                chk("hsize", k, 32'(hsize), 32'(vecs[k].e_sz));
            end
            if (vecs[k].chk_wd) chk("hwdata", k, hwdata, vecs[k].e_wd);
            chk("rsp_valid", k, 32'(rsp_valid), 32'(vecs[k].e_rv));
            chk("rsp_err", k, 32'(rsp_err), 32'(vecs[k].e_err));
            if (vecs[k].chk_rd) chk("rsp_rdata", k, rsp_rdata, vecs[k].e_rd);
        end

        // Asynchronous reset while a read sits in a waited data phase.
        @(posedge clk); #1;
        drive(H, 32'h200, L, HSIZE_WORD, 32'h55, H, L, Z32);
        @(posedge clk); #1;
        drive(L, Z32, L, HSIZE_BYTE, Z32, H, L, Z32);
        @(posedge clk); #1;
        drive(L, Z32, L, HSIZE_BYTE, Z32, L, L, Z32);
        @(negedge clk);
        chk("mid_hwdata_before_rst", 900, hwdata, 32'h55);
        #1;
        rst_n = 1'b0;
        hready = 1'b1;
        #1;
        chk("arst_req_ready", 900, 32'(req_ready), 32'h1);
        chk("arst_htrans", 900, 32'(htrans), 32'(HTRANS_IDLE));
        chk("arst_hwdata", 900, hwdata, Z32);
        chk("arst_rsp_valid", 900, 32'(rsp_valid), Z32);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("post_rst_rsp_valid", 901 + c, 32'(rsp_valid), Z32);
            chk("post_rst_htrans", 901 + c, 32'(htrans), 32'(HTRANS_IDLE));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahbl_master_bridge.md
# ahbl_master_bridge

AHB-Lite initiator that turns a simple valid/ready request stream into single AHB-Lite transfers and returns one response per request. It drives the same bus that our AHB-Lite SRAM controllers and other slaves sit on, so internal engines (DMA, debug loaders, test sequencers) can issue bus traffic without implementing AHB-Lite phase rules. Address and data phases are pipelined, and slave wait states and two-cycle error responses are handled correctly.

## Interface
Parameters:
- W_ADDR, 32, address width
- W_DATA, 32, data width (power of two bytes, ≥ 8)

Ports:
- clk  in  1  single clock; everything is synchronous to its rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present; requester holds it stable until accepted
- req_ready  out  1  request accepted when high together with req_valid
- req_addr  in  W_ADDR  byte address, aligned to req_size
- req_write  in  1  1 = write, 0 = read
- req_size  in  3  HSIZE encoding, at most log2(W_DATA/8)
- req_wdata  in  W_DATA  write data, byte lanes already positioned
- rsp_valid  out  1  single-cycle pulse, one per accepted request, in order
- rsp_rdata  out  W_DATA  read data, valid with rsp_valid (undefined for writes)
- rsp_err  out  1  slave returned ERROR
- ahblm_haddr  out  W_ADDR, ahblm_hwrite  out  1, ahblm_htrans  out  2, ahblm_hsize  out  3, ahblm_hburst  out  3, ahblm_hprot  out  4, ahblm_hmastlock  out  1, ahblm_hwdata  out  W_DATA: AHB-Lite master outputs
- ahblm_hready  in  1, ahblm_hresp  in  1, ahblm_hrdata  in  W_DATA: AHB-Lite master inputs

## Operation
- Two registered stages: address-phase (aph_valid, addr, write, size, wdata) and data-phase (dph_valid, write, wdata).
- Request acceptance loads the address-phase register. req_ready = !aph_valid || (ahblm_hready && !err_first). Here err_first = dph_valid && ahblm_hresp && !ahblm_hready.
- ahblm_htrans = NONSEQ (2'b10) when aph_valid && !err_first, otherwise IDLE. The bridge never issues SEQ or BUSY.
- ahblm_hburst = SINGLE (3'b000), ahblm_hprot = 4'b0011, ahblm_hmastlock = 0, all constant.
- When ahblm_hready is high, the address-phase contents move to the data-phase register, or the data-phase register clears if aph_valid is low.
- ahblm_hwdata is driven from the data-phase register.
- Error handling: in the first error cycle (hresp=1, hready=0), a pending address phase is shown as IDLE. That transfer is kept, not dropped, and is issued as NONSEQ from the second error cycle onward. Request order is preserved.
- Response: rsp_valid = dph_valid && ahblm_hready. At the same time, rsp_rdata = ahblm_hrdata and rsp_err = ahblm_hresp. There is no response backpressure.
- Reset values: req_ready = 1, ahblm_htrans = IDLE, haddr/hwrite/hsize/hwdata = 0, rsp_valid = 0, rsp_err = 0.
- Reset in the middle of a transfer drops all state. The requester must also be reset.

## Timing
- Request accepted at edge N → NONSEQ on the bus in cycle N+1.
- With zero wait states, the data phase is cycle N+2 and rsp_valid is high in cycle N+2.
- Each slave wait state adds one cycle to the response and stalls the next address phase (htrans/haddr held stable).
- ERROR: rsp_valid with rsp_err=1 occurs in the second error cycle. A transfer held back during the error is issued one cycle after the error's first cycle.
- Peak throughput is one transfer per cycle (with pipelining enabled).

## Configuration
- AHBL_MASTER_BRIDGE_PIPELINE_EN defined: behaviour as above; a new address phase overlaps the current data phase.
- Not defined: req_ready additionally requires !dph_valid, and aph_valid cannot rise while dph_valid is set.
  - The bus never carries overlapping phases.
  - Throughput is one transfer per 3 cycles at zero wait states.
  - err_first masking is never exercised.

## Structure
- Shared package ahbl_pkg:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ constants
  - HSIZE_BYTE/HALF/WORD constants
  - HBURST_SINGLE constant
  - default HPROT constant
- Single module; no sub-module is natural, since both stages are a few registers plus hready-gated enables.

## Test plan
- Single read, zero wait: addr 0x100, hrdata 0xDEADBEEF → NONSEQ at N+1, rsp_valid at N+2 with rdata 0xDEADBEEF, rsp_err=0.
- Back-to-back writes to 0x0, 0x4, 0x8 (pipeline on): htrans NONSEQ for 3 consecutive cycles; hwdata trails haddr by exactly one cycle; 3 rsp_valid pulses in consecutive cycles.
- Slave inserts 2 wait states on the first of two reads: second haddr/htrans held stable for 3 cycles; responses in order.
- ERROR on a write while a read to 0x20 is pending: htrans IDLE in the first error cycle; NONSEQ 0x20 in the second; rsp_err=1 for the write, then a normal read response.
- Pipeline macro undefined: 4 requests presented continuously → 4 responses over 12 cycles; hready never seen high while both phases are active.
- rst_n asserted mid-data-phase: outputs at reset values immediately (asynchronously); no rsp_valid after release until a new request.
